// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fills the IF/ID register from a
// combinational instruction memory, and drains the pipeline before signalling done.
module fetch_ctrl #(
    parameter int N         = 32,
    parameter int D         = 32,
    parameter int DRAIN_CYC = 4,
    parameter logic [N-1:0] NOP_WORD = N'(32'b000100_00000_00000_00000_00000_000000)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_target,
    input  logic [N-1:0] imem_instr,
    output logic [N-1:0] imem_addr,
    output logic [N-1:0] if_id_instr,
    output logic [N-1:0] if_id_pc,
    output logic         if_id_valid,
    output logic         busy,
    output logic         done,
    output logic [15:0]  fetch_count,
    output logic [15:0]  stall_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [N-1:0]  LAST_PC   = N'(D - 1);
    localparam logic [N-1:0]  END_PC    = N'(D);
    localparam logic [DW-1:0] DRAIN_TOP = DW'(DRAIN_CYC - 1);

    state_t          state_q, state_d;
    logic [N-1:0]    pc_q, pc_d;
    logic [N-1:0]    instr_q, instr_d;
    logic [N-1:0]    ifpc_q, ifpc_d;
    logic            valid_q, valid_d;
    logic [15:0]     fcnt_q, fcnt_d;
    logic [15:0]     scnt_q, scnt_d;
    logic [DW-1:0]   drain_q, drain_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    always_comb begin
        // NOTE: every _d gets a hold default first, so no path can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        fcnt_d  = fcnt_q;
        scnt_d  = scnt_q;
        drain_d = drain_q;

        unique case (state_q)
            IDLE: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    // Wrong-path word is flushed and never counted.
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    pc_d    = redirect_target;
                    if (redirect_target >= END_PC) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end
                end else if (stall) begin
                    scnt_d = sat_inc(scnt_q);
                end else begin
                    instr_d = imem_instr;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    fcnt_d  = sat_inc(fcnt_q);
                    if (pc_q == LAST_PC) begin
                        pc_d    = END_PC;
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                // A late-resolving branch in the last instruction resumes fetching.
                if (redirect && (redirect_target < END_PC)) begin
                    pc_d    = redirect_target;
                    drain_d = '0;
                    state_d = RUN;
                end else if (!stall) begin
                    drain_d = drain_q + 1'b1;
                    if (drain_q == DRAIN_TOP) state_d = DONE;
                end
            end
            DONE: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            ifpc_q  <= '0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
            scnt_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
            scnt_q  <= scnt_d;
            drain_q <= drain_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ifpc_q;
    assign if_id_valid = valid_q;
    assign fetch_count = fcnt_q;
    assign stall_count = scnt_q;
    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a 32-word combinational memory model and a
// linear sequence of steps with hand-computed expectations.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset, start, stall, redirect;
    logic [31:0] redirect_target, imem_instr, imem_addr;
    logic [31:0] if_id_instr, if_id_pc;
    logic        if_id_valid, busy, done;
    logic [15:0] fetch_count, stall_count;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .redirect(redirect), .redirect_target(redirect_target),
        .imem_instr(imem_instr), .imem_addr(imem_addr),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .busy(busy), .done(done), .fetch_count(fetch_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input int i);
        return {8'hA5, 8'(i), 8'h3C, 8'(~i)};
    endfunction

    assign imem_instr = (imem_addr < 32) ? mw(int'(imem_addr)) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input int p);
        check({tag, "_pc"}, if_id_pc, 32'(p));
        check({tag, "_instr"}, if_id_instr, mw(p));
        check({tag, "_valid"}, {31'b0, if_id_valid}, 32'd1);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_instr"}, if_id_instr, NOP);
        check({tag, "_valid"}, {31'b0, if_id_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        step(); step();
        reset = 1'b0;
        check_bubble("rst");
        check("rst_pc", imem_addr, 32'd0);
        check("rst_ifpc", if_id_pc, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_fcnt", {16'b0, fetch_count}, 32'd0);

        // IDLE ignores stall and redirect
        redirect = 1'b1; redirect_target = 32'd5; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        check("idle_pc", imem_addr, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);

        // Straight-line run of all 32 words
        start = 1'b1;
        step();
        start = 1'b0;
        check("run_busy", {31'b0, busy}, 32'd1);
        check("run_addr0", imem_addr, 32'd0);
        check_bubble("run_first");
        for (int i = 0; i < 32; i++) begin
            step();
            check_fetch("seq", i);
        end
        check("seq_fcnt", {16'b0, fetch_count}, 32'd32);
        for (int k = 0; k < 4; k++) begin
            check("drain_done", {31'b0, done}, 32'd0);
            step();
            check_bubble("drain");
        end
        check("end_done", {31'b0, done}, 32'd1);
        check("end_busy", {31'b0, busy}, 32'd0);
        check("end_scnt", {16'b0, stall_count}, 32'd0);
        start = 1'b1; redirect = 1'b1; redirect_target = 32'd3;
        step();
        start = 1'b0; redirect = 1'b0;
        check("done_sticky", {31'b0, done}, 32'd1);
        check("done_fcnt", {16'b0, fetch_count}, 32'd32);

        // Reset after DONE
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_done", {31'b0, done}, 32'd0);
        check("rst2_fcnt", {16'b0, fetch_count}, 32'd0);

        // Stall for 2 cycles while pc=4
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_fetch("pre_stall", 3);
        check("pre_stall_addr", imem_addr, 32'd4);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check_fetch("stall_hold", 3);
            check("stall_addr", imem_addr, 32'd4);
        end
        stall = 1'b0;
        check("stall_cnt", {16'b0, stall_count}, 32'd2);
        step();
        check_fetch("post_stall", 4);
        check("post_stall_fcnt", {16'b0, fetch_count}, 32'd5);

        // Redirect to 2 when pc=13
        for (int i = 5; i < 13; i++) step();
        check("pre_redir_addr", imem_addr, 32'd13);
        redirect = 1'b1; redirect_target = 32'd2;
        step();
        redirect = 1'b0;
        check_bubble("redir");
        check("redir_addr", imem_addr, 32'd2);
        check("redir_fcnt", {16'b0, fetch_count}, 32'd13);
        step();
        check_fetch("redir_t0", 2);
        step();
        check_fetch("redir_t1", 3);
        check("redir_fcnt2", {16'b0, fetch_count}, 32'd15);

        // Redirect and stall together, target 8
        redirect = 1'b1; stall = 1'b1; redirect_target = 32'd8;
        step();
        redirect = 1'b0; stall = 1'b0;
        check("rs_addr", imem_addr, 32'd8);
        check("rs_scnt", {16'b0, stall_count}, 32'd2);
        check_bubble("rs");
        step();
        check_fetch("rs_t", 8);

        // Run to the end, then redirect from DRAIN after 2 bubbles
        for (int i = 9; i < 32; i++) step();
        check_fetch("last", 31);
        check("last_fcnt", {16'b0, fetch_count}, 32'd39);
        step(); step();
        check_bubble("dr2");
        check("dr2_busy", {31'b0, busy}, 32'd1);
        redirect = 1'b1; redirect_target = 32'd20;
        step();
        redirect = 1'b0;
        check("drred_addr", imem_addr, 32'd20);
        check_bubble("drred");
        step();
        check_fetch("drred_t", 20);
        check("drred_done", {31'b0, done}, 32'd0);
        check("drred_fcnt", {16'b0, fetch_count}, 32'd40);

        // Out-of-range redirect enters DRAIN; stall holds the drain count
        redirect = 1'b1; redirect_target = 32'd40;
        step();
        redirect = 1'b0;
        check_bubble("oor");
        check("oor_busy", {31'b0, busy}, 32'd1);
        stall = 1'b1;
        step(); step();
        stall = 1'b0;
        check("drstall_scnt", {16'b0, stall_count}, 32'd2);
        step(); step(); step();
        check("oor_done3", {31'b0, done}, 32'd0);
        step();
        check("oor_done4", {31'b0, done}, 32'd1);

        // Reset mid-RUN at pc=10
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_fetch("mid", 9);
        check("mid_addr", imem_addr, 32'd10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_addr", imem_addr, 32'd0);
        check("mrst_ifpc", if_id_pc, 32'd0);
        check_bubble("mrst");
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_fcnt", {16'b0, fetch_count}, 32'd0);
        check("mrst_scnt", {16'b0, stall_count}, 32'd0);
        check("mrst_done", {31'b0, done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
